// File: rtl/pll_lock_reset_seq.sv
// ----------------------------------------------------------------------------
// pll_lock_reset_seq
//   Sequences the fabric reset from the PLL lock and device init indications.
//   The fabric reset is released only after the lock has been stable for
//   LOCK_STABLE_CYCLES clocks. It is dropped again on lock loss or for
//   HOLD_CYCLES clocks after a soft-reset request.
//
// Ports
//   CLK            in   fabric clock (CCC OUT0_FABCLK_0)
//   EXT_RST_N      in   async active-low reset of every register
//   PLL_LOCK       in   PLL lock, asynchronous to CLK (2-flop synchronized)
//   INIT_DONE      in   device init complete, asynchronous (2-flop synchronized)
//   SW_RST_REQ     in   synchronous soft-reset request, acted on only in RUN
//   FABRIC_RESET_N out  registered active-low reset to downstream fabric
//   READY          out  high exactly when FABRIC_RESET_N is high
//   STATE          out  WAIT=00, COUNT=01, RUN=10, HOLD=11
//   LOSS_CNT       out  saturating count of lock losses seen in RUN
// ----------------------------------------------------------------------------
module pll_lock_reset_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES        = 16
) (
  input  logic       CLK,
  input  logic       EXT_RST_N,
  input  logic       PLL_LOCK,
  input  logic       INIT_DONE,
  input  logic       SW_RST_REQ,
  output logic       FABRIC_RESET_N,
  output logic       READY,
  output logic [1:0] STATE,
  output logic [7:0] LOSS_CNT
);

  // Counters only need to reach PARAM-1, so $clog2(PARAM) bits suffice.
  localparam int unsigned CW = $clog2(LOCK_STABLE_CYCLES);
  localparam int unsigned HW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'b00,
    ST_COUNT = 2'b01,
    ST_RUN   = 2'b10,
    ST_HOLD  = 2'b11
  } state_e;

  logic          lock_meta_q;
  logic          lock_s_q;
  logic          init_meta_q;
  logic          init_s_q;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [HW-1:0] hold_q;
  logic [7:0]    loss_q;
  logic          rst_n_q;
  logic          ready_q;

  // Two-stage synchronizers for the asynchronous status inputs.
  always_ff @(posedge CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      init_meta_q <= 1'b0;
      init_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= PLL_LOCK;
      lock_s_q    <= lock_meta_q;
      init_meta_q <= INIT_DONE;
      init_s_q    <= init_meta_q;
    end
  end

  always_ff @(posedge CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      hold_q  <= '0;
      loss_q  <= '0;
      rst_n_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          cnt_q  <= '0;
          hold_q <= '0;
          if (lock_s_q && init_s_q) begin
            state_q <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (!lock_s_q || !init_s_q) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            rst_n_q <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_RUN: begin
          // Lock loss wins over a simultaneous soft-reset request; INIT_DONE
          // is deliberately not looked at once running.
          if (!lock_s_q) begin
            state_q <= ST_WAIT;
            rst_n_q <= 1'b0;
            ready_q <= 1'b0;
            if (loss_q != 8'hFF) begin
              loss_q <= loss_q + 8'd1;
            end
          end else if (SW_RST_REQ) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            rst_n_q <= 1'b0;
            ready_q <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (!lock_s_q || (hold_q == HOLD_LAST)) begin
            state_q <= ST_WAIT;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end

        default: begin
          state_q <= ST_WAIT;
          rst_n_q <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign FABRIC_RESET_N = rst_n_q;
  assign READY          = ready_q;
  assign STATE          = state_q;
  assign LOSS_CNT       = loss_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_reset_seq
//   Directed bench for pll_lock_reset_seq with LOCK_STABLE_CYCLES=16 and
//   HOLD_CYCLES=8. Stimulus pushes expected observations tagged with the
//   clock-edge index at which they must hold; a monitor samples on the
//   falling edge and pops/compares every entry due at that edge.
// ----------------------------------------------------------------------------
module tb_pll_lock_reset_seq;

  localparam logic [1:0] WT = 2'b00;
  localparam logic [1:0] CT = 2'b01;
  localparam logic [1:0] RN = 2'b10;
  localparam logic [1:0] HD = 2'b11;

  logic       clk = 1'b0;
  logic       EXT_RST_N;
  logic       PLL_LOCK;
  logic       INIT_DONE;
  logic       SW_RST_REQ;
  logic       FABRIC_RESET_N;
  logic       READY;
  logic [1:0] STATE;
  logic [7:0] LOSS_CNT;

  pll_lock_reset_seq #(
    .LOCK_STABLE_CYCLES(16),
    .HOLD_CYCLES       (8)
  ) dut (
    .CLK           (clk),
    .EXT_RST_N     (EXT_RST_N),
    .PLL_LOCK      (PLL_LOCK),
    .INIT_DONE     (INIT_DONE),
    .SW_RST_REQ    (SW_RST_REQ),
    .FABRIC_RESET_N(FABRIC_RESET_N),
    .READY         (READY),
    .STATE         (STATE),
    .LOSS_CNT      (LOSS_CNT)
  );

  always #5 clk = ~clk;

  // Edge counter: value N after the N-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       rstn;
    logic [7:0] loss;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int c, input logic [1:0] st, input logic rn,
                      input logic [7:0] ls, input string nm);
    exp_t e;
    e.cyc  = c;
    e.st   = st;
    e.rstn = rn;
    e.loss = ls;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due at the current edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s not sampled: due at edge %0d, now edge %0d", e.name, e.cyc, cyc);
      end else if (STATE !== e.st || FABRIC_RESET_N !== e.rstn ||
                   READY !== e.rstn || LOSS_CNT !== e.loss) begin
        errors++;
        $display("FAIL %s edge %0d: STATE got %b want %b, FABRIC_RESET_N got %b want %b, READY got %b want %b, LOSS_CNT got %0d want %0d",
                 e.name, cyc, STATE, e.st, FABRIC_RESET_N, e.rstn, READY, e.rstn, LOSS_CNT, e.loss);
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int f0;
    int s0;
    int exp_loss;

    EXT_RST_N  = 1'b1;
    PLL_LOCK   = 1'b0;
    INIT_DONE  = 1'b1;
    SW_RST_REQ = 1'b0;
    #1;
    EXT_RST_N = 1'b0;

    // Reset values while held in reset.
    tick();
    tick();
    push(cyc, WT, 1'b0, 8'd0, "reset_values");
    tick();
    EXT_RST_N = 1'b1;
    tick();
    tick();
    tick();
    push(cyc, WT, 1'b0, 8'd0, "idle_no_lock");

    // Power-up; SW_RST_REQ held high through WAIT/COUNT must not matter.
    SW_RST_REQ = 1'b1;
    tick();
    e0 = cyc + 1;
    PLL_LOCK = 1'b1;
    push(e0 + 1,  WT, 1'b0, 8'd0, "pwr_sync_wait");
    push(e0 + 2,  CT, 1'b0, 8'd0, "pwr_enter_count");
    push(e0 + 17, CT, 1'b0, 8'd0, "pwr_last_held");
    push(e0 + 18, RN, 1'b1, 8'd0, "pwr_release");
    wait_until(e0 + 16);
    SW_RST_REQ = 1'b0;
    push(e0 + 22, RN, 1'b1, 8'd0, "pwr_run_steady");
    wait_until(e0 + 22);

    // Soft reset, with a second request during HOLD that must not extend it.
    s0 = cyc + 1;
    SW_RST_REQ = 1'b1;
    push(s0,      HD, 1'b0, 8'd0, "soft_enter_hold");
    push(s0 + 7,  HD, 1'b0, 8'd0, "soft_hold_last");
    push(s0 + 8,  WT, 1'b0, 8'd0, "soft_hold_exit");
    push(s0 + 9,  CT, 1'b0, 8'd0, "soft_recount");
    push(s0 + 24, CT, 1'b0, 8'd0, "soft_last_held");
    push(s0 + 25, RN, 1'b1, 8'd0, "soft_release");
    tick();
    SW_RST_REQ = 1'b0;
    wait_until(s0 + 2);
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    wait_until(s0 + 28);

    // Lock loss in RUN.
    f0 = cyc + 1;
    PLL_LOCK = 1'b0;
    push(f0 + 1, RN, 1'b1, 8'd0, "loss_sync_delay");
    push(f0 + 2, WT, 1'b0, 8'd1, "loss_drop");
    wait_until(f0 + 5);

    // Lock glitch of 3 sampled cycles at stability count 10.
    e0 = cyc + 1;
    PLL_LOCK = 1'b1;
    push(e0 + 2, CT, 1'b0, 8'd1, "glitch_enter_count");
    wait_until(e0 + 11);
    PLL_LOCK = 1'b0;
    push(e0 + 12, CT, 1'b0, 8'd1, "glitch_count10");
    push(e0 + 13, CT, 1'b0, 8'd1, "glitch_sync_delay");
    push(e0 + 14, WT, 1'b0, 8'd1, "glitch_abort");
    wait_until(e0 + 14);
    PLL_LOCK = 1'b1;
    push(e0 + 16, WT, 1'b0, 8'd1, "glitch_waiting");
    push(e0 + 17, CT, 1'b0, 8'd1, "glitch_recount");
    push(e0 + 18, CT, 1'b0, 8'd1, "glitch_no_early_run");
    push(e0 + 32, CT, 1'b0, 8'd1, "glitch_last_held");
    push(e0 + 33, RN, 1'b1, 8'd1, "glitch_release");
    wait_until(e0 + 36);

    // Lock loss and soft request on the same FSM edge: loss path wins.
    f0 = cyc + 1;
    PLL_LOCK = 1'b0;
    push(f0 + 1, RN, 1'b1, 8'd1, "simul_before");
    push(f0 + 2, WT, 1'b0, 8'd2, "simul_loss_wins");
    push(f0 + 3, WT, 1'b0, 8'd2, "simul_no_hold");
    wait_until(f0 + 1);
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    wait_until(f0 + 5);

    // Lock loss during HOLD exits early without counting a loss.
    e0 = cyc + 1;
    PLL_LOCK = 1'b1;
    push(e0 + 18, RN, 1'b1, 8'd2, "hold_pre_run");
    wait_until(e0 + 20);
    s0 = cyc + 1;
    SW_RST_REQ = 1'b1;
    push(s0, HD, 1'b0, 8'd2, "hold_enter");
    tick();
    SW_RST_REQ = 1'b0;
    wait_until(s0 + 1);
    PLL_LOCK = 1'b0;
    push(s0 + 3, HD, 1'b0, 8'd2, "hold_sync_delay");
    push(s0 + 4, WT, 1'b0, 8'd2, "hold_lock_exit");
    push(s0 + 9, WT, 1'b0, 8'd2, "hold_stays_wait");
    wait_until(s0 + 10);

    // 300 further losses: counter saturates at 255.
    exp_loss = 2;
    for (int i = 0; i < 300; i++) begin
      tick();
      e0 = cyc + 1;
      PLL_LOCK = 1'b1;
      push(e0 + 18, RN, 1'b1, 8'(exp_loss), "sat_run");
      wait_until(e0 + 18);
      PLL_LOCK = 1'b0;
      f0 = e0 + 19;
      if (exp_loss < 255) exp_loss++;
      push(f0 + 2, WT, 1'b0, 8'(exp_loss), "sat_loss");
      wait_until(f0 + 2);
    end

    // Async reset pulse between edges during RUN.
    tick();
    e0 = cyc + 1;
    PLL_LOCK = 1'b1;
    push(e0 + 18, RN, 1'b1, 8'd255, "arst_pre_run");
    wait_until(e0 + 20);
    EXT_RST_N = 1'b0;
    push(cyc, WT, 1'b0, 8'd0, "arst_immediate");
    @(negedge clk);
    #1;
    EXT_RST_N = 1'b1;
    e0 = cyc + 1;
    push(e0 + 1,  WT, 1'b0, 8'd0, "arst_sync_wait");
    push(e0 + 2,  CT, 1'b0, 8'd0, "arst_recount");
    push(e0 + 17, CT, 1'b0, 8'd0, "arst_last_held");
    push(e0 + 18, RN, 1'b1, 8'd0, "arst_release");
    wait_until(e0 + 21);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
